// File: rtl/alu_share_arb_pkg.sv
// alu_share_arb_pkg
// Shared definitions for the ALU sharing arbiter: the ALU op codes,
// the sequencer state encoding and the op-code legality check.
// No ports (package).
package alu_share_arb_pkg;

  localparam int ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  // 100, 110 and 111 are unassigned codes.
  function automatic logic alu_op_legal(input logic [ALU_OP_W-1:0] op);
    logic legal;
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT: legal = 1'b1;
      default:                                    legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_share_arb_rr.sv
// rr_arb2
// Two-way round-robin grant. A lone valid is granted directly; when both
// are valid, the requester not served last wins. The pointer only moves
// when the grant is actually taken (advance).
// Ports:
//   clk, rst_n   clock, async active-low reset
//   valid[1:0]   request present per requester
//   advance      granted request accepted this cycle
//   grant[1:0]   one-hot grant (all zero when nothing is valid)
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  // id of the requester served last; resets to 1 so req0 wins the first tie
  logic last;

  assign grant[0] = valid[0] & (~valid[1] | last);
  assign grant[1] = valid[1] & (~valid[0] | ~last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (advance) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb
// Arbitrates two requesters onto one shared combinational ALU and
// sequences each op through IDLE -> ISSUE -> RESP.
//
//   state | meaning
//   IDLE  | waiting for a request; grant via round-robin, ready to winner
//   ISSUE | latched op/operands on alu_*; result captured at cycle end
//   RESP  | result held on rsp_*; waits for the owner's rsp_ready
//
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   reqN_valid/ready/op/a/b       request channels (N = 0, 1)
//   rspN_valid/ready              response channels (N = 0, 1)
//   rsp_result/zero/err           response payload shared by both channels
//   alu_op/a/b, alu_result/zero   shared ALU interface
//   busy                          not in IDLE
//   op_count                      legal ops completed, wraps
module alu_share_arb
  import alu_share_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [ALU_OP_W-1:0] req0_op,
  input  logic [DATA_W-1:0]   req0_a,
  input  logic [DATA_W-1:0]   req0_b,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [ALU_OP_W-1:0] req1_op,
  input  logic [DATA_W-1:0]   req1_a,
  input  logic [DATA_W-1:0]   req1_b,
  output logic                rsp0_valid,
  input  logic                rsp0_ready,
  output logic                rsp1_valid,
  input  logic                rsp1_ready,
  output logic [DATA_W-1:0]   rsp_result,
  output logic                rsp_zero,
  output logic                rsp_err,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic                alu_zero,
  output logic                busy,
  output logic [CNT_W-1:0]    op_count
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_ISSUE = ISSUE;
  localparam logic [1:0] ST_RESP  = RESP;

  logic [1:0] state;
  logic [1:0] grant;
  logic       rsp_id;
  logic       req_hs;
  logic       rsp_hs;

  rr_arb2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   ({req1_valid, req0_valid}),
    .advance (req_hs),
    .grant   (grant)
  );

  assign req0_ready = (state == ST_IDLE) & grant[0];
  assign req1_ready = (state == ST_IDLE) & grant[1];
  // a grant implies the matching valid, so any grant in IDLE is a handshake
  assign req_hs     = (state == ST_IDLE) & (|grant);

  assign rsp0_valid = (state == ST_RESP) & ~rsp_id;
  assign rsp1_valid = (state == ST_RESP) &  rsp_id;
  assign rsp_hs     = (rsp0_valid & rsp0_ready) | (rsp1_valid & rsp1_ready);

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rsp_id     <= 1'b0;
      alu_op     <= ALU_ADD;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_hs) begin
            rsp_id <= grant[1];
            alu_op <= grant[1] ? req1_op : req0_op;
            alu_a  <= grant[1] ? req1_a  : req0_a;
            alu_b  <= grant[1] ? req1_b  : req0_b;
            state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // illegal codes still reach the ALU, but its answer is discarded
          if (alu_op_legal(alu_op)) begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rsp_err    <= 1'b0;
          end else begin
            rsp_result <= '0;
            rsp_zero   <= 1'b1;
            rsp_err    <= 1'b1;
          end
          state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_hs) begin
            if (!rsp_err) begin
              op_count <= op_count + CNT_W'(1);
            end
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
module tb_alu_share_arb;
  import alu_share_arb_pkg::*;

  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]    req0_op, req1_op;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [DW-1:0] rsp_result;
  logic          rsp_zero, rsp_err;
  logic [2:0]    alu_op;
  logic [DW-1:0] alu_a, alu_b, alu_result;
  logic          alu_zero;
  logic          busy;
  logic [CW-1:0] op_count;

  always #5 clk = ~clk;

  alu_share_arb #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy), .op_count(op_count)
  );

  // external shared ALU; unassigned codes give a nonzero pattern
  always_comb begin
    case (alu_op)
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_AND: alu_result = alu_a & alu_b;
      ALU_OR:  alu_result = alu_a | alu_b;
      ALU_SLT: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  typedef struct packed {
    logic          id;
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
    logic          zero;
    logic          err;
  } vec_t;

  vec_t q0[$];
  vec_t q1[$];
  vec_t sb[$];
  int   grant_log[$];

  int n_pass = 0;
  int n_total = 0;
  int viol = 0;
  logic hs0, hs1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic sb_compare(input logic id);
    vec_t e;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL sb_unexpected_rsp: got response on channel %0d expected none at %0t", id, $time);
    end else begin
      e = sb.pop_front();
      check("rsp_id", 32'(id), 32'(e.id));
      check("rsp_result", rsp_result, e.res);
      check("rsp_zero", 32'(rsp_zero), 32'(e.zero));
      check("rsp_err", 32'(rsp_err), 32'(e.err));
    end
  endtask

  // request driver + scoreboard monitor: sample at negedge, drive after posedge
  initial begin
    vec_t tmp;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    forever begin
      @(negedge clk);
      hs0 = rst_n && req0_valid && req0_ready;
      hs1 = rst_n && req1_valid && req1_ready;
      if (rst_n) begin
        if (rsp0_valid && rsp1_valid) viol++;
        if (busy && (req0_ready || req1_ready)) viol++;
        if (hs0) begin sb.push_back(q0[0]); grant_log.push_back(0); end
        if (hs1) begin sb.push_back(q1[0]); grant_log.push_back(1); end
        if (rsp0_valid && rsp0_ready) sb_compare(1'b0);
        if (rsp1_valid && rsp1_ready) sb_compare(1'b1);
      end
      @(posedge clk);
      #1;
      if (hs0 && q0.size() > 0) tmp = q0.pop_front();
      if (hs1 && q1.size() > 0) tmp = q1.pop_front();
      req0_valid = (q0.size() > 0);
      if (q0.size() > 0) begin req0_op = q0[0].op; req0_a = q0[0].a; req0_b = q0[0].b; end
      req1_valid = (q1.size() > 0);
      if (q1.size() > 0) begin req1_op = q1[0].op; req1_a = q1[0].a; req1_b = q1[0].b; end
    end
  end

  task automatic wait_idle(input string tag);
    int stable = 0;
    for (int i = 0; i < 400 && stable < 2; i++) begin
      @(negedge clk);
      if (q0.size() == 0 && q1.size() == 0 && sb.size() == 0 && !busy) stable++;
      else stable = 0;
    end
    check({tag, "_drain"}, 32'(stable >= 2), 32'd1);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    #1 rst_n = 1'b0;
    q0.delete(); q1.delete(); sb.delete(); grant_log.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    int   exp_cnt;
    logic found, saw;

    tbl[0] = '{1'b0, ALU_ADD, 32'd5,          32'd1,          32'd6,          1'b0, 1'b0};
    tbl[1] = '{1'b1, ALU_SUB, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 1'b0};
    tbl[2] = '{1'b0, ALU_AND, 32'hFF00_FF00,  32'h0FF0_0FF0,  32'h0F00_0F00,  1'b0, 1'b0};
    tbl[3] = '{1'b1, ALU_OR,  32'h0000_00F0,  32'h0000_000F,  32'h0000_00FF,  1'b0, 1'b0};
    tbl[4] = '{1'b0, ALU_SLT, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0};
    tbl[5] = '{1'b1, ALU_SLT, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0};
    tbl[6] = '{1'b0, 3'b100,  32'd3,          32'd4,          32'd0,          1'b1, 1'b1};
    tbl[7] = '{1'b1, 3'b110,  32'd3,          32'd4,          32'd0,          1'b1, 1'b1};
    tbl[8] = '{1'b1, 3'b111,  32'd3,          32'd4,          32'd0,          1'b1, 1'b1};
    tbl[9] = '{1'b0, ALU_ADD, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b0};

    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'(ALU_ADD));
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 32'd0);
    check("rst_rsp_err", 32'({rsp_err, rsp_zero}), 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    #1 rst_n = 1'b1;

    // single op: timing through ISSUE and RESP
    q0.push_back('{1'b0, ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0});
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (req0_ready) found = 1;
    end
    check("t1_req0_ready", 32'(found), 32'd1);
    check("t1_req1_ready", 32'(req1_ready), 32'd0);
    @(negedge clk);
    check("t1_issue_op", 32'(alu_op), 32'(ALU_ADD));
    check("t1_issue_a", alu_a, 32'd5);
    check("t1_issue_b", alu_b, 32'd7);
    check("t1_issue_busy", 32'(busy), 32'd1);
    check("t1_issue_rsp0", 32'(rsp0_valid), 32'd0);
    @(negedge clk);
    check("t1_resp_rsp0", 32'(rsp0_valid), 32'd1);
    check("t1_resp_rsp1", 32'(rsp1_valid), 32'd0);
    @(negedge clk);
    check("t1_op_count", 32'(op_count), 32'd1);
    check("t1_idle", 32'(busy), 32'd0);

    // table of single ops, one at a time
    reset_dut();
    exp_cnt = 0;
    foreach (tbl[i]) begin
      if (tbl[i].id) q1.push_back(tbl[i]);
      else q0.push_back(tbl[i]);
      wait_idle("tbl");
      if (!tbl[i].err) exp_cnt++;
    end
    check("tbl_op_count", 32'(op_count), 32'(exp_cnt));

    // simultaneous requests after reset: req0 first
    reset_dut();
    q0.push_back('{1'b0, ALU_SUB, 32'd10, 32'd10, 32'd0, 1'b1, 1'b0});
    q1.push_back('{1'b1, ALU_OR, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0});
    wait_idle("sim");
    check("sim_grants", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      check("sim_first", 32'(grant_log[0]), 32'd0);
      check("sim_second", 32'(grant_log[1]), 32'd1);
    end
    check("sim_op_count", 32'(op_count), 32'd2);

    // fairness: both held for four ops
    grant_log.delete();
    q0.push_back('{1'b0, ALU_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0});
    q0.push_back('{1'b0, ALU_AND, 32'hFFFF_0000, 32'h00FF_FF00, 32'h00FF_0000, 1'b0, 1'b0});
    q1.push_back('{1'b1, ALU_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0});
    q1.push_back('{1'b1, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0});
    wait_idle("fair");
    check("fair_grants", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() == 4) begin
      check("fair_g0", 32'(grant_log[0]), 32'd0);
      check("fair_g1", 32'(grant_log[1]), 32'd1);
      check("fair_g2", 32'(grant_log[2]), 32'd0);
      check("fair_g3", 32'(grant_log[3]), 32'd1);
    end
    check("fair_op_count", 32'(op_count), 32'd6);

    // backpressure on rsp1 with req0 waiting
    @(posedge clk);
    #2 rsp1_ready = 1'b0;
    q1.push_back('{1'b1, ALU_OR, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0});
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (rsp1_valid) found = 1;
    end
    check("bp_rsp1_valid", 32'(found), 32'd1);
    q0.push_back('{1'b0, ALU_ADD, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(rsp1_valid), 32'd1);
      check("bp_hold_result", rsp_result, 32'h1234_5678);
      check("bp_req0_valid", 32'(req0_valid), 32'd1);
      check("bp_req0_ready", 32'(req0_ready), 32'd0);
    end
    @(posedge clk);
    #2 rsp1_ready = 1'b1;
    wait_idle("bp");
    check("bp_op_count", 32'(op_count), 32'd8);

    // reset during ISSUE
    q0.push_back('{1'b0, ALU_ADD, 32'd9, 32'd9, 32'd18, 1'b0, 1'b0});
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (busy) found = 1;
    end
    check("mid_reached_issue", 32'(found), 32'd1);
    check("mid_issue_a", alu_a, 32'd9);
    #1 rst_n = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_alu_a", alu_a, 32'd0);
    check("mid_alu_b", alu_b, 32'd0);
    check("mid_rsp_result", rsp_result, 32'd0);
    check("mid_op_count", 32'(op_count), 32'd0);
    q0.delete(); q1.delete(); sb.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    saw = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid || busy) saw = 1;
    end
    check("mid_no_rsp_after", 32'(saw), 32'd0);
    check("mid_op_count_after", 32'(op_count), 32'd0);

    check("invariants", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
